md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multi-cycle multiply/divide controller owning the HI/LO register pair.
//   Executes MULT/MULTU/DIV/DIVU over a fixed latency and handles MTHI/MTLO.
//   Sits beside the ALU in the EX stage. The decoder drives md_op/start.
//   Hazard logic stalls on (start | busy).
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous, active-high
//   start   in   1   accept md_op this cycle (single-cycle pulse)
//   md_op   in   3   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 rsvd (=NONE)
//   rs_val  in   32  operand A / dividend / MTHI-MTLO source
//   rt_val  in   32  operand B / divisor
//   busy    out  1   operation in flight
//   done    out  1   one-cycle pulse; HI/LO were updated this edge
//   hi      out  32  HI register
//   lo      out  32  LO register
// BEHAVIOUR
//   - Reset: state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0.
//     A reset in RUN aborts the op; no HI/LO write.
//   - FSM IDLE->RUN: start & op in {1..4} & !busy. Latch op and operands.
//     Signed ops sign-extend both operands to 33 bits; unsigned ops zero-extend.
//     Load cnt = MULT_CYCLES-1 or DIV_CYCLES-1. busy=1 from the next cycle.
//   - RUN: cnt decrements each cycle. At cnt==0: commit HI/LO, done=1, go to IDLE, busy=0.
//     Total: start at edge T, results visible after edge T+N (N = the op's CYCLES).
//   - Multiply: 64-bit product of the 33-bit extended operands; hi=[63:32], lo=[31:0].
//   - Divide: lo=quotient, hi=remainder. Truncate toward zero; remainder takes the dividend's sign.
//     0x80000000 / -1 (DIV) -> lo=0x80000000, hi=0.
//   - MTHI/MTLO in IDLE: write hi/lo with rs_val at the same edge.
//     Zero latency, busy stays 0, done=1 for that cycle.
//   - Arbitration: start while busy is ignored, including MTHI/MTLO.
//     HI/LO never change mid-op. The pipeline must not issue.
//   - NONE/rsvd with start: no effect.
//   - Commit uses the latched operands only. rs_val/rt_val may change after the start cycle.
// CONFIGURATION
//   MD_DIV0_GUARD_EN defined:
//     DIV/DIVU with rt_val==0 never enters RUN. hi/lo unchanged.
//     done pulses the next cycle, busy stays 0.
//   MD_DIV0_GUARD_EN undefined:
//     Divide-by-zero runs the full DIV_CYCLES.
//     Commits hi=dividend (latched rs), lo=32'hFFFFFFFF.
// STRUCTURE
//   - md_defs.vh: op encodings MD_NONE..MD_MTLO, state encodings MD_IDLE/MD_RUN.
//     Shared with the decoder.
//   - One sub-module, md_operand_ext: {32-bit val, signed} -> 33-bit extended value.
//     Instantiated twice.
//   - Arithmetic is behavioural (* and / on latched operands). The counter models latency only.
// TESTING
//   1. MULT rs=-3, rt=7 -> busy 5 cycles; done; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   2. MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE, after 5 cycles.
//   3. DIV rs=-7, rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU same operands -> lo=0x7FFFFFFC, hi=1.
//   4. MTHI during DIV busy -> ignored; hi after done equals the divide result.
//      MTLO 0x1234 in IDLE -> lo=0x1234 next edge, busy never set.
//   5. reset pulsed at cnt==3 of a DIV -> busy=0, hi=lo=0, no done pulse.
//   6. DIV rt=0 -> guard on: done next cycle, hi/lo unchanged.
//      Guard off: 10 cycles, hi=rs, lo=0xFFFFFFFF.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e    : operation encodings driven by the decoder on md_op
//   - md_state_e : controller states (IDLE / RUN)
//   - DATA_W     : architectural register width
//   - small classification helpers for md_op_e
package md_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Multi-cycle arithmetic ops (MULT, MULTU, DIV, DIVU)
  function automatic logic op_is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_operand_ext.sv
// md_operand_ext: widens a 32-bit operand to 33 bits so that signed and
// unsigned operations share one signed datapath.
// Ports:
//   val  in  DATA_W    raw operand
//   sgn  in  1         1 = sign-extend, 0 = zero-extend
//   ext  out DATA_W+1  extended operand (always interpreted as signed)
module md_operand_ext
  import md_unit_pkg::*;
(
  input  logic [DATA_W-1:0]        val,
  input  logic                     sgn,
  output logic signed [DATA_W:0]   ext
);

  assign ext = sgn ? {val[DATA_W-1], val} : {1'b0, val};

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide controller owning the HI/LO pair.
// MULT/MULTU/DIV/DIVU run for a fixed number of busy cycles and then commit
// HI/LO; MTHI/MTLO write HI/LO immediately when idle. Any start while busy
// is dropped, so HI/LO never change mid-operation.
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>=1)
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous active-high reset
//   start   in   1   accept md_op this cycle
//   md_op   in   3   operation (md_op_e encoding)
//   rs_val  in   32  operand A / dividend / MTHI-MTLO source
//   rt_val  in   32  operand B / divisor
//   busy    out  1   operation in flight
//   done    out  1   one-cycle pulse, HI/LO updated at this edge
//   hi      out  32  HI register
//   lo      out  32  LO register
// Configuration macro:
//   MD_DIV0_GUARD_EN  when defined, a divide by zero is not executed: HI/LO
//                     keep their values and done pulses right away. When
//                     undefined, it runs the full DIV_CYCLES and commits
//                     hi = dividend, lo = all ones.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e              state;
  logic [CNT_W-1:0]       cnt;
  md_op_e                 op_in;
  logic                   sgn_in;
  logic signed [DATA_W:0] a_ext;
  logic signed [DATA_W:0] b_ext;
  logic                   accept;
  logic                   div0_skip;

  logic signed [DATA_W:0] a_p0;
  logic signed [DATA_W:0] b_p0;
  logic                   div_p0;
  logic [2*DATA_W-1:0]    commit_res;

  // 64-bit product of the 33-bit extended operands; {hi, lo}
  function automatic logic [2*DATA_W-1:0] mul_res(
    input logic signed [DATA_W:0] a,
    input logic signed [DATA_W:0] b
  );
    logic signed [2*DATA_W+1:0] p;
    p = (2*DATA_W+2)'(a) * (2*DATA_W+2)'(b);
    return p[2*DATA_W-1:0];
  endfunction

  // Truncating divide, remainder follows the dividend's sign; {rem, quot}.
  // The 33-bit datapath makes 0x80000000 / -1 yield quotient 0x80000000.
  // Divide by zero returns {dividend, all ones}.
  function automatic logic [2*DATA_W-1:0] div_res(
    input logic signed [DATA_W:0] a,
    input logic signed [DATA_W:0] b
  );
    logic signed [DATA_W:0] q;
    logic signed [DATA_W:0] r;
    if (b == '0) begin
      return {a[DATA_W-1:0], {DATA_W{1'b1}}};
    end
    q = a / b;
    r = a % b;
    return {r[DATA_W-1:0], q[DATA_W-1:0]};
  endfunction

  assign op_in  = md_op_e'(md_op);
  assign sgn_in = op_is_signed(op_in);

  md_operand_ext u_ext_a (
    .val (rs_val),
    .sgn (sgn_in),
    .ext (a_ext)
  );

  md_operand_ext u_ext_b (
    .val (rt_val),
    .sgn (sgn_in),
    .ext (b_ext)
  );

  // A new op is only taken in IDLE; busy is high exactly in RUN.
  always_comb begin
    accept    = 1'b0;
    div0_skip = 1'b0;
    if ((state == MD_IDLE) && start && op_is_arith(op_in)) begin
`ifdef MD_DIV0_GUARD_EN
      if (op_is_div(op_in) && (rt_val == '0)) begin
        div0_skip = 1'b1;
      end else begin
        accept = 1'b1;
      end
`else
      accept = 1'b1;
`endif
    end
  end

  // Stage p0: operands captured at acceptance; the commit reads only these.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= a_ext;
      b_p0   <= b_ext;
      div_p0 <= op_is_div(op_in);
    end
  end

  always_comb begin
    commit_res = div_p0 ? div_res(a_p0, b_p0) : mul_res(a_p0, b_p0);
  end

  // Control FSM and HI/LO. The counter only models latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (state == MD_IDLE) begin
        if (accept) begin
          state <= MD_RUN;
          busy  <= 1'b1;
          cnt   <= op_is_div(op_in) ? DIV_LOAD : MULT_LOAD;
        end else if (div0_skip) begin
          done <= 1'b1;
        end else if (start && (op_in == MD_MTHI)) begin
          hi   <= rs_val;
          done <= 1'b1;
        end else if (start && (op_in == MD_MTLO)) begin
          lo   <= rs_val;
          done <= 1'b1;
        end
      end else begin
        if (cnt == '0) begin
          hi    <= commit_res[2*DATA_W-1:DATA_W];
          lo    <= commit_res[DATA_W-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  // reference HI/LO state
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural reference: updates m_hi/m_lo, returns expected busy cycles
  // and whether a done pulse is expected at all.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit dn);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    lat = 0;
    dn  = 1'b1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = sa * sb;
        m_hi = p[63:32];
        m_lo = p[31:0];
        lat = MULT_CYCLES;
      end
      OP_MULTU: begin
        u = {32'd0, a} * {32'd0, b};
        m_hi = u[63:32];
        m_lo = u[31:0];
        lat = MULT_CYCLES;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
`ifdef MD_DIV0_GUARD_EN
          lat = 0;
`else
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
          lat = DIV_CYCLES;
`endif
        end else begin
          if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
          lat = DIV_CYCLES;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: dn = 1'b0;
    endcase
  endtask

  // Issue one op at a negedge and follow it until done; returns at a negedge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] h0, l0;
    int  lat, exp_lat;
    bit  exp_done, changed, seen;
    model(op, a, b, exp_lat, exp_done);
    h0 = hi;
    l0 = lo;
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    // operands are free to change once the op is accepted
    start  = 1'b0;
    md_op  = 3'($urandom_range(0, 7));
    rs_val = $urandom;
    rt_val = $urandom;
    if (!exp_done) begin
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
      return;
    end
    lat = 0;
    changed = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) lat++;
      if ((hi !== h0) || (lo !== l0)) changed = 1'b1;
      // an MTHI/MTLO while busy must be ignored
      if ((k == 1) && (exp_lat >= 3)) begin
        start  = 1'b1;
        md_op  = ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO;
        rs_val = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_seen_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_midop_chg"}, 32'(changed), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw_done;
    n_cmp = 0;
    n_err = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
    chk("mult_hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_lo_k", lo, 32'hFFFF_FFEB);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu");
    chk("multu_hi_k", hi, 32'h0000_0001);
    chk("multu_lo_k", lo, 32'hFFFF_FFFE);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div");
    chk("div_lo_k", lo, 32'hFFFF_FFFD);
    chk("div_hi_k", hi, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, "divu");
    chk("divu_lo_k", lo, 32'h7FFF_FFFC);
    chk("divu_hi_k", hi, 32'h0000_0001);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lo_k", lo, 32'h8000_0000);
    chk("div_ovf_hi_k", hi, 32'h0000_0000);
    run_op(OP_MTLO, 32'h0000_1234, 32'd0, "mtlo");
    chk("mtlo_lo_k", lo, 32'h0000_1234);
    run_op(OP_MTHI, 32'h0BAD_F00D, 32'd0, "mthi");
    run_op(OP_NONE, 32'h5555_5555, 32'd3, "none");
    run_op(3'd7, 32'h6666_6666, 32'd3, "rsvd");

    // divide by zero
    run_op(OP_DIV, 32'h1357_9BDF, 32'd0, "div0");
`ifndef MD_DIV0_GUARD_EN
    chk("div0_hi_k", hi, 32'h1357_9BDF);
    chk("div0_lo_k", lo, 32'hFFFF_FFFF);
`endif

    // reset while a divide is running (cnt==3 at the 7th busy sample)
    start = 1'b1;
    md_op = OP_DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    saw_done = 1'b0;
    repeat (DIV_CYCLES + 2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // randomized ops against the reference
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
